stream_word_packer: RTL

//   Packs RATIO consecutive narrow words from a valid/ready stream into one wide

---
 rtl/stream_word_packer_if.sv | 26 ++
 rtl/stream_word_packer.sv | 92 +++++++++
 2 files changed

// File: rtl/stream_word_packer_if.sv
// Valid/ready handshake bundle for stream_word_packer: narrow input stream plus packed wide output stream.
// Modport master drives the input stream and the output ready; modport slave is the packer side.
interface stream_word_packer_if #(
    parameter int WORD_WIDTH_IN = 8,
    parameter int RATIO         = 4
);
    logic [WORD_WIDTH_IN-1:0]       in_data_i;
    logic                           in_valid_i;
    logic                           in_last_i;
    logic                           in_ready_o;
    logic [WORD_WIDTH_IN*RATIO-1:0] out_data_o;
    logic                           out_valid_o;
    logic                           out_last_o;
    logic [$clog2(RATIO+1)-1:0]     out_count_o;
    logic                           out_ready_i;

    modport master (
        output in_data_i, in_valid_i, in_last_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o, out_last_o, out_count_o
    );

    modport slave (
        input  in_data_i, in_valid_i, in_last_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o, out_last_o, out_count_o
    );
endinterface

// File: rtl/stream_word_packer.sv
// Packs RATIO narrow stream words into one wide word; 'last' closes a zero-filled partial word.
// Define PACK_MSB_FIRST_EN to place the first word of each wide word in the top lane.
module stream_word_packer #(
    parameter int WORD_WIDTH_IN = 8,
    parameter int RATIO         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_word_packer_if.slave   bus
);
    localparam int OW = WORD_WIDTH_IN * RATIO;
    localparam int CW = $clog2(RATIO + 1);
    localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [LW-1:0] r_lane_cnt;
    logic [OW-1:0] r_acc;
    logic [OW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_out_last;
    logic [CW-1:0] r_out_count;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_lane_full;
    logic          w_complete;
    logic [LW-1:0] w_lane_sel;
    logic [OW-1:0] w_merged;

    assign w_in_ready  = !r_out_valid || bus.out_ready_i;
    assign w_accept    = bus.in_valid_i && w_in_ready;
    assign w_lane_full = (r_lane_cnt == LW'(RATIO - 1));
    assign w_complete  = w_accept && (w_lane_full || bus.in_last_i);

`ifdef PACK_MSB_FIRST_EN
    assign w_lane_sel = LW'(RATIO - 1) - r_lane_cnt;
`else
    assign w_lane_sel = r_lane_cnt;
`endif

    // Accumulator with the incoming word inserted; lanes not yet filled are forced to zero.
    always_comb begin
        w_merged = r_acc;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (LW'(i) == w_lane_sel) begin
                w_merged[i*WORD_WIDTH_IN +: WORD_WIDTH_IN] = bus.in_data_i;
`ifdef PACK_MSB_FIRST_EN
            end else if (LW'(i) < w_lane_sel) begin
`else
            end else if (LW'(i) > w_lane_sel) begin
`endif
                w_merged[i*WORD_WIDTH_IN +: WORD_WIDTH_IN] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_cnt  <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_count <= '0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_lane_cnt <= '0;
                    r_acc      <= '0;
                end else begin
                    r_lane_cnt <= r_lane_cnt + LW'(1);
                    r_acc      <= w_merged;
                end
            end
            // A completion overrides the drain so back-to-back wide words leave no bubble.
            if (w_complete) begin
                r_out_data  <= w_merged;
                r_out_count <= CW'(r_lane_cnt) + CW'(1);
                r_out_last  <= bus.in_last_i;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_last_o  = r_out_last;
    assign bus.out_count_o = r_out_count;

endmodule
